// File: rtl/lsu_mem_port.sv
// RV32 load/store initiator driving the word-wide main memory port; sub-word stores use read-modify-write.
// Optional build macro LSU_MISALIGN_CHECK_EN turns misaligned H/W accesses into error responses.
module lsu_mem_port #(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);
    localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

    typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_t;
    state_t state;

    logic [2:0]  op_funct3;
    logic [1:0]  op_lane;
    logic [15:0] op_wdata;

    logic bad_funct3, out_of_range, misaligned, req_error;

    always_comb begin
        bad_funct3   = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110)
                    || (req_write && req_funct3[2]);
        out_of_range = (req_addr < STARTING_ADDR) || (req_addr > LAST_ADDR);
`ifdef LSU_MISALIGN_CHECK_EN
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misaligned   = 1'b0;
`endif
        req_error    = bad_funct3 || out_of_range || misaligned;
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Lane extraction for loads and lane insertion for RMW both work on the live memory word.
    always_comb begin
        sel_byte = mem_data_out[{op_lane, 3'b000} +: 8];
        sel_half = op_lane[1] ? mem_data_out[31:16] : mem_data_out[15:0];
        case (op_funct3[1:0])
            2'b00:   load_ext = {{24{sel_byte[7] & ~op_funct3[2]}}, sel_byte};
            2'b01:   load_ext = {{16{sel_half[15] & ~op_funct3[2]}}, sel_half};
            default: load_ext = mem_data_out;
        endcase
        merged = mem_data_out;
        if (op_funct3[1:0] == 2'b00)
            merged[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
        else if (op_lane[1])
            merged[31:16] = op_wdata;
        else
            merged[15:0] = op_wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_address    <= STARTING_ADDR;
            mem_data_in    <= '0;
            mem_read_write <= 1'b0;
            op_funct3      <= '0;
            op_lane        <= '0;
            op_wdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_funct3   <= req_funct3;
                        op_lane     <= req_addr[1:0];
                        op_wdata    <= req_wdata[15:0];
                        mem_address <= {req_addr[31:2], 2'b00};
                        req_ready   <= 1'b0;
                        if (req_error) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else if (!req_write) begin
                            state <= READ;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            mem_data_in    <= req_wdata;
                            mem_read_write <= 1'b1;
                            state          <= WRITE;
                        end else begin
                            state <= RMW_READ;
                        end
                    end
                end
                READ: begin
                    resp_rdata <= load_ext;
                    resp_error <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_READ: begin
                    mem_data_in    <= merged;
                    mem_read_write <= 1'b1;
                    state          <= WRITE;
                end
                WRITE: begin
                    mem_read_write <= 1'b0;
                    resp_rdata     <= '0;
                    resp_error     <= 1'b0;
                    resp_valid     <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a bench-side memory, an arithmetic reference model and a per-cycle compare process.
module tb_lsu_mem_port;
    localparam logic [31:0] SA    = 32'h0100_0000;
    localparam logic [31:0] DEPTH = 32'h0010_0000;
    localparam int          WORDS = 256;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    lsu_mem_port #(.STARTING_ADDR(SA), .MEM_DEPTH_BYTES(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_read_write(mem_read_write)
    );

    function automatic logic in_win(input logic [31:0] a);
        return (a >= SA) && (a < SA + 32'(WORDS * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - SA) >> 2);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h8899AABB : 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Main memory stand-in: combinational read, write on posedge while mem_read_write is high.
    logic [31:0] mem [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic preloaded = 1'b0;

    always_comb mem_data_out = in_win(mem_address) ? mem[widx(mem_address)] : 32'h0;

    always @(posedge clock) begin
        if (!preloaded) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
            preloaded <= 1'b1;
        end else if (mem_read_write === 1'b1 && in_win(mem_address)) begin
            mem[widx(mem_address)] <= mem_data_in;
        end
    end

    // Reference model: outcome of one request from the access rules, in plain byte arithmetic.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rdata, output int lat,
                         output logic wr, output logic [31:0] nword);
        int size, off;
        logic [31:0] word, mask, val;
        logic legal;
        legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = !legal || (a < SA) || (a > SA + DEPTH - 32'd4);
`ifdef LSU_MISALIGN_CHECK_EN
        if (legal && f3[1:0] == 2'd1 && (a % 2) != 0) err = 1'b1;
        if (legal && f3[1:0] == 2'd2 && (a % 4) != 0) err = 1'b1;
`endif
        size = 1 << f3[1:0];
        off  = ((a % 4) / size) * size;
        word = in_win(a) ? ref_mem[widx(a)] : 32'h0;
        mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        val  = (word >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        rdata = (err || w) ? 32'h0 : val;
        nword = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        wr    = w && !err;
        lat   = err ? 1 : ((w && size < 4) ? 3 : 2);
    endtask

    // Expectation handed from the driver to the compare process at issue time.
    logic        p_err, p_wr;
    logic [31:0] p_rdata, p_nword, p_addr;
    int          p_lat;

    logic        rst_sampled = 1'b0;
    always @(posedge clock) rst_sampled <= reset_n;

    bit          busy = 0;
    int          k = 0;
    int          e_lat = 0;
    logic        e_err = 1'b0, e_wr = 1'b0;
    logic [31:0] e_rdata = '0, e_nword = '0, e_addr = '0;
    logic [31:0] hold_rdata = '0;
    logic        hold_err = 1'b0;

    initial begin : compare
        forever begin
            @(negedge clock);
            if (!rst_sampled) begin
                busy = 0;
                hold_rdata = '0;
                hold_err = 1'b0;
                check("rst_req_ready", req_ready, 1);
                check("rst_resp_valid", resp_valid, 0);
                check("rst_resp_rdata", resp_rdata, 0);
                check("rst_resp_error", resp_error, 0);
                check("rst_mem_address", mem_address, SA);
                check("rst_mem_data_in", mem_data_in, 0);
                check("rst_mem_rw", mem_read_write, 0);
            end else if (busy) begin
                k++;
                check("resp_valid", resp_valid, k == e_lat);
                check("req_ready_busy", req_ready, 0);
                check("mem_rw", mem_read_write, e_wr && (k == e_lat - 1));
                check("mem_address", mem_address, e_addr);
                if (e_wr && k == e_lat - 1) check("mem_data_in", mem_data_in, e_nword);
                if (k == e_lat) begin
                    check("resp_rdata", resp_rdata, e_rdata);
                    check("resp_error", resp_error, e_err);
                    hold_rdata = e_rdata;
                    hold_err = e_err;
                    busy = 0;
                end
            end else begin
                check("idle_req_ready", req_ready, 1);
                check("idle_resp_valid", resp_valid, 0);
                check("idle_mem_rw", mem_read_write, 0);
                check("hold_rdata", resp_rdata, hold_rdata);
                check("hold_error", resp_error, hold_err);
                if (req_valid && reset_n) begin
                    busy = 1;
                    k = 0;
                    e_lat = p_lat; e_err = p_err; e_wr = p_wr;
                    e_rdata = p_rdata; e_nword = p_nword; e_addr = p_addr;
                end
            end
        end
    end

    task automatic start_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             output logic wr, output logic [31:0] nw);
        logic err;
        logic [31:0] rd;
        int lat;
        model(w, f3, a, wd, err, rd, lat, wr, nw);
        p_err = err; p_rdata = rd; p_lat = lat; p_wr = wr; p_nword = nw;
        p_addr = {a[31:2], 2'b00};
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 once it is idle again.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic pin, input logic [31:0] pin_rdata, input logic pin_err);
        logic wr;
        logic [31:0] nw;
        bit done;
        done = 0;
        start_req(w, f3, a, wd, wr, nw);
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge clock); #1;
            if (req_ready) done = 1;
        end
        check("complete", done, 1);
        if (wr && in_win(a)) ref_mem[widx(a)] = nw;
        if (pin) begin
            check("pin_rdata", resp_rdata, pin_rdata);
            check("pin_error", resp_error, pin_err);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        logic wr;
        logic [31:0] nw;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        do_req(0, 3'b000, 32'h0100_0013, 32'h0, 1, 32'hFFFF_FF88, 0);
        do_req(0, 3'b100, 32'h0100_0013, 32'h0, 1, 32'h0000_0088, 0);
        do_req(0, 3'b001, 32'h0100_0012, 32'h0, 1, 32'hFFFF_8899, 0);
        do_req(0, 3'b101, 32'h0100_0010, 32'h0, 1, 32'h0000_AABB, 0);
        do_req(0, 3'b010, 32'h0100_0010, 32'h0, 1, 32'h8899_AABB, 0);
        do_req(0, 3'b000, 32'h0100_0010, 32'h0, 1, 32'hFFFF_FFBB, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        do_req(0, 3'b010, 32'h0100_0012, 32'h0, 1, 32'h0, 1);
`else
        do_req(0, 3'b010, 32'h0100_0012, 32'h0, 1, 32'h8899_AABB, 0);
`endif

        // SH abandoned by reset while in RMW_READ
        start_req(1, 3'b001, 32'h0100_0010, 32'h0000_CAFE, wr, nw);
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("rst_abort_ready", req_ready, 1);
        check("rst_abort_mem", mem[4], 32'h8899_AABB);
        repeat (2) @(posedge clock);
        #1;
        do_req(0, 3'b010, 32'h0100_0010, 32'h0, 1, 32'h8899_AABB, 0);

        do_req(1, 3'b000, 32'h0100_0011, 32'h1234_565A, 1, 32'h0, 0);
        check("sb_mem_word", mem[4], 32'h8899_5ABB);
        do_req(0, 3'b010, 32'h0100_0010, 32'h0, 1, 32'h8899_5ABB, 0);

        do_req(1, 3'b010, 32'h0100_0020, 32'hDEAD_BEEF, 1, 32'h0, 0);
        do_req(0, 3'b010, 32'h0100_0020, 32'h0, 1, 32'hDEAD_BEEF, 0);

        do_req(1, 3'b001, 32'h0100_0012, 32'h0000_CAFE, 0, 32'h0, 0);
        do_req(0, 3'b001, 32'h0100_0012, 32'h0, 1, 32'hFFFF_CAFE, 0);
        do_req(0, 3'b100, 32'h0100_0020, 32'h0, 1, 32'h0000_00EF, 0);

        do_req(0, 3'b010, 32'h00FF_FFFC, 32'h0, 1, 32'h0, 1);
        do_req(1, 3'b100, 32'h0100_0010, 32'h0000_00FF, 1, 32'h0, 1);
        do_req(0, 3'b011, 32'h0100_0010, 32'h0, 1, 32'h0, 1);
        do_req(0, 3'b110, 32'h0100_0010, 32'h0, 1, 32'h0, 1);
        do_req(0, 3'b010, 32'h0110_0000, 32'h0, 1, 32'h0, 1);
        do_req(0, 3'b010, 32'h010F_FFFC, 32'h0, 1, 32'h0, 0);
        check("err_no_write", mem[4], 32'hCAFE_5ABB);

        for (int i = 0; i < WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) check($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        end
        check("mem_word_8", mem[8], ref_mem[8]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
